controller: RTL and testbench

BIST sequencing controller. A `start` rising edge launches one self-test run: a one-cycle `init` phase, a `running` window of exactly NCLOCK clock cycles with periodic single-cycle `toggle` pulses, then a one-cycle `finish` pulse. After that, `bist_end` stays high until the next run or reset. It sits between the test-access logic that issues `start` and the BIST datapath (pattern generator and signature register), which consumes `init`, `running` and `toggle`.

---
 rtl/controller.sv | 53 +++++
 tb/tb_controller.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/controller.sv
// controller: BIST sequencer producing init, a fixed-length running window with periodic toggles, then finish/bist_end.
module controller #(
    parameter int NCLOCK     = 650,
    parameter int TOGGLE_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic init,
    output logic running,
    output logic toggle,
    output logic finish,
    output logic bist_end
);
    localparam int CW = $clog2(NCLOCK);
    localparam int TW = TOGGLE_DIV > 1 ? $clog2(TOGGLE_DIV) : 1;
    typedef enum logic [1:0] {IDLE, INIT, RUN, FIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic start_q, trig, last;
    assign trig = start & ~start_q;
    assign last = cnt == CW'(NCLOCK - 1);
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = trig ? INIT : IDLE;
            INIT: state_n = RUN;
            RUN:  state_n = last ? FIN : RUN;
            FIN:  state_n = IDLE;
        endcase
    end
    // tcnt tracks the toggle phase directly so no modulo is needed on cnt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            start_q  <= 1'b1;
            bist_end <= 1'b0;
        end else begin
            state    <= state_n;
            start_q  <= start;
            cnt      <= (state == RUN && !last) ? cnt + 1'b1 : '0;
            tcnt     <= (state == RUN && tcnt != TW'(TOGGLE_DIV - 1)) ? tcnt + 1'b1 : '0;
            bist_end <= state_n == FIN ? 1'b1 : state_n == INIT ? 1'b0 : bist_end;
        end
    end
    assign init    = state == INIT;
    assign running = state == RUN;
    assign finish  = state == FIN;
    assign toggle  = running && tcnt == TW'(TOGGLE_DIV - 1);
endmodule

// File: tb/tb_controller.sv
// tb_controller: directed checks of run sequencing, start-edge filtering and reset abort.
module tb_controller;
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, start_d = 1'b0;
    logic init, running, toggle, finish, bist_end;
    logic init_d, running_d, toggle_d, finish_d, bist_end_d;
    int errors = 0, checks = 0;
    int n_init, n_run, n_tog, n_fin, i_init, i_run0, i_run1, i_fin, i_tog0;
    bit bad_excl, bad_tog, be_at_init, be_at_fin, be_end;

    controller #(.NCLOCK(10), .TOGGLE_DIV(5)) dut (
        .clk(clk), .reset(reset), .start(start), .init(init), .running(running),
        .toggle(toggle), .finish(finish), .bist_end(bist_end));
    controller dut_d (
        .clk(clk), .reset(reset), .start(start_d), .init(init_d), .running(running_d),
        .toggle(toggle_d), .finish(finish_d), .bist_end(bist_end_d));

    always #5 clk = ~clk;

    // Samples one DUT for n cycles at negedges; index 0 is the negedge before the trigger edge
    task automatic observe(input bit d, input int n);
        logic a, b, c, f, e;
        n_init = 0; n_run = 0; n_tog = 0; n_fin = 0;
        i_init = -1; i_run0 = -1; i_run1 = -1; i_fin = -1; i_tog0 = -1;
        bad_excl = 0; bad_tog = 0; be_at_init = 0; be_at_fin = 0; be_end = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            {a, b, c, f, e} = d ? {init_d, running_d, toggle_d, finish_d, bist_end_d}
                                : {init, running, toggle, finish, bist_end};
            if (a) begin n_init++; if (i_init < 0) i_init = i; be_at_init = e; end
            if (b) begin n_run++; if (i_run0 < 0) i_run0 = i; i_run1 = i; end
            if (c) begin n_tog++; if (i_tog0 < 0) i_tog0 = i; if (!b) bad_tog = 1; end
            if (f) begin n_fin++; i_fin = i; be_at_fin = e; end
            if (int'(a) + int'(b) + int'(f) > 1) bad_excl = 1;
            be_end = e;
        end
    endtask

    task automatic pulse_run(input int n);
        @(posedge clk); #1 start = 1'b1;
        fork
            observe(0, n);
            begin repeat (2) @(posedge clk); #1 start = 1'b0; end
        join
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({init, running, toggle, finish, bist_end} !== 5'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 00000", {init, running, toggle, finish, bist_end}); end
        checks++; if ({init_d, running_d, toggle_d, finish_d, bist_end_d} !== 5'b0) begin errors++; $display("FAIL reset_outputs_default: got %b expected 00000", {init_d, running_d, toggle_d, finish_d, bist_end_d}); end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({init, running, finish, bist_end} !== 4'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0000", {init, running, finish, bist_end}); end
    endtask

    task automatic test_normal;
        pulse_run(16);
        checks++; if (n_init !== 1 || i_init !== 1) begin errors++; $display("FAIL normal_init: got count %0d at %0d expected 1 at 1", n_init, i_init); end
        checks++; if (n_run !== 10) begin errors++; $display("FAIL normal_running_count: got %0d expected 10", n_run); end
        checks++; if (i_run0 !== 2 || i_run1 !== 11) begin errors++; $display("FAIL normal_running_window: got %0d..%0d expected 2..11", i_run0, i_run1); end
        checks++; if (n_tog !== 2 || i_tog0 !== 6) begin errors++; $display("FAIL normal_toggle: got count %0d first %0d expected 2 first 6", n_tog, i_tog0); end
        checks++; if (n_fin !== 1 || i_fin !== 12) begin errors++; $display("FAIL normal_finish: got count %0d at %0d expected 1 at 12", n_fin, i_fin); end
        checks++; if (be_at_fin !== 1'b1 || be_end !== 1'b1) begin errors++; $display("FAIL normal_bist_end: got at_fin %0d end %0d expected 1 1", be_at_fin, be_end); end
        checks++; if (bad_excl || bad_tog) begin errors++; $display("FAIL normal_exclusive: got excl %0d tog_out %0d expected 0 0", bad_excl, bad_tog); end
    endtask

    task automatic test_back_to_back;
        checks++; if (bist_end !== 1'b1) begin errors++; $display("FAIL b2b_bist_end_before: got %0d expected 1", bist_end); end
        pulse_run(16);
        checks++; if (n_init !== 1 || be_at_init !== 1'b0) begin errors++; $display("FAIL b2b_init_clears: got init %0d bist_end %0d expected 1 0", n_init, be_at_init); end
        checks++; if (n_run !== 10 || n_tog !== 2) begin errors++; $display("FAIL b2b_run: got running %0d toggles %0d expected 10 2", n_run, n_tog); end
        checks++; if (n_fin !== 1 || be_end !== 1'b1) begin errors++; $display("FAIL b2b_finish: got finish %0d bist_end %0d expected 1 1", n_fin, be_end); end
    endtask

    task automatic test_midrun_start;
        @(posedge clk); #1 start = 1'b1;
        fork
            observe(0, 20);
            begin
                repeat (2) @(posedge clk); #1 start = 1'b0;
                repeat (3) @(posedge clk); #1 start = 1'b1;
                repeat (2) @(posedge clk); #1 start = 1'b0;
            end
        join
        checks++; if (n_init !== 1) begin errors++; $display("FAIL midstart_init: got %0d expected 1", n_init); end
        checks++; if (n_run !== 10 || n_tog !== 2) begin errors++; $display("FAIL midstart_run: got running %0d toggles %0d expected 10 2", n_run, n_tog); end
        checks++; if (n_fin !== 1 || i_fin !== 12) begin errors++; $display("FAIL midstart_finish: got count %0d at %0d expected 1 at 12", n_fin, i_fin); end
    endtask

    task automatic test_start_held_reset;
        @(posedge clk); #1 reset = 1'b0; start = 1'b1;
        fork
            observe(0, 15);
            begin
                repeat (2) @(posedge clk); #1 reset = 1'b1;
                repeat (3) @(posedge clk); #1 start = 1'b0;
            end
        join
        checks++; if (n_init !== 0 || n_run !== 0) begin errors++; $display("FAIL held_start_no_run: got init %0d running %0d expected 0 0", n_init, n_run); end
        pulse_run(16);
        checks++; if (n_run !== 10 || i_run0 !== 2 || n_fin !== 1) begin errors++; $display("FAIL held_start_fresh_run: got running %0d first %0d finish %0d expected 10 2 1", n_run, i_run0, n_fin); end
    endtask

    task automatic test_midrun_reset;
        @(posedge clk); #1 start = 1'b1;
        fork
            observe(0, 20);
            begin
                repeat (2) @(posedge clk); #1 start = 1'b0;
                repeat (5) @(posedge clk); #1 reset = 1'b0;
                #1;
                checks++; if ({init, running, toggle, finish, bist_end} !== 5'b0) begin errors++; $display("FAIL midreset_immediate: got %b expected 00000", {init, running, toggle, finish, bist_end}); end
                repeat (2) @(posedge clk); #1 reset = 1'b1;
            end
        join
        checks++; if (n_run !== 5) begin errors++; $display("FAIL midreset_running: got %0d expected 5", n_run); end
        checks++; if (n_fin !== 0 || be_end !== 1'b0) begin errors++; $display("FAIL midreset_abort: got finish %0d bist_end %0d expected 0 0", n_fin, be_end); end
        pulse_run(16);
        checks++; if (n_run !== 10 || n_tog !== 2 || n_fin !== 1 || be_end !== 1'b1) begin errors++; $display("FAIL midreset_recover: got running %0d toggles %0d finish %0d bist_end %0d expected 10 2 1 1", n_run, n_tog, n_fin, be_end); end
    endtask

    task automatic test_default_params;
        @(posedge clk); #1 start_d = 1'b1;
        fork
            observe(1, 660);
            begin repeat (2) @(posedge clk); #1 start_d = 1'b0; end
        join
        checks++; if (n_run !== 650 || i_run0 !== 2) begin errors++; $display("FAIL default_running: got %0d first %0d expected 650 first 2", n_run, i_run0); end
        checks++; if (n_tog !== 13 || i_tog0 !== 51) begin errors++; $display("FAIL default_toggle: got %0d first %0d expected 13 first 51", n_tog, i_tog0); end
        checks++; if (n_fin !== 1 || i_fin !== 652 || be_end !== 1'b1) begin errors++; $display("FAIL default_finish: got count %0d at %0d bist_end %0d expected 1 at 652 1", n_fin, i_fin, be_end); end
        checks++; if (bad_excl || bad_tog) begin errors++; $display("FAIL default_exclusive: got excl %0d tog_out %0d expected 0 0", bad_excl, bad_tog); end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_back_to_back;
        test_midrun_start;
        test_start_held_reset;
        test_midrun_reset;
        test_default_params;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
